// File: rtl/eprisc_pkg.sv
// eprisc fetch: shared widths, reset PC and the fetch-entry bundle.
// Used by eprisc_fetch_unit and eprisc_fetch_fifo.
package eprisc_pkg;

  localparam int EPRISC_ADDR_W = 8;
  localparam int EPRISC_DATA_W = 32;
  localparam logic [EPRISC_ADDR_W-1:0] EPRISC_RESET_PC = '0;

  typedef struct packed {
    logic [EPRISC_DATA_W-1:0] instr;
    logic [EPRISC_ADDR_W-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/eprisc_fetch_fifo.sv
// eprisc prefetch FIFO: DEPTH x W entries, synchronous flush,
// power-of-2 pointer wrap by masking.
module eprisc_fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 40,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic [AW:0]  count,
  output logic         full,
  output logic         empty
);

  localparam logic [AW-1:0] MASK = AW'(DEPTH - 1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push, do_pop;

  assign count = count_q;
  assign full  = (count_q == (AW+1)'(DEPTH));
  assign empty = (count_q == '0);
  assign rdata = mem_q[rd_ptr_q];

  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = wdata;
        wr_ptr_d = (wr_ptr_q + 1'b1) & MASK;
      end
      if (do_pop) begin
        rd_ptr_d = (rd_ptr_q + 1'b1) & MASK;
      end
      if (do_push && !do_pop) begin
        count_d = count_q + 1'b1;
      end else if (do_pop && !do_push) begin
        count_d = count_q - 1'b1;
      end
    end
  end

  // Storage is cleared on reset so the head reads zero out of reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/eprisc_fetch_unit.sv
// eprisc fetch stage: PC, 1-cycle ROM capture, prefetch FIFO, redirect.
// Optional EPRISC_FETCH_PERF_EN adds push/redirect counters.
module eprisc_fetch_unit
  import eprisc_pkg::*;
#(
  parameter int ADDR_W = EPRISC_ADDR_W,
  parameter int DATA_W = EPRISC_DATA_W,
  parameter int DEPTH  = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(EPRISC_RESET_PC)
) (
  input  logic              iClk,
  input  logic              iRst,
  output logic [ADDR_W-1:0] oRomAddr,
  output logic              oRomEn,
  input  logic [DATA_W-1:0] iRomData,
  output logic              oValid,
  output logic [DATA_W-1:0] oInstr,
  output logic [ADDR_W-1:0] oInstrPC,
  input  logic              iReady,
`ifdef EPRISC_FETCH_PERF_EN
  output logic [15:0]       oFetchCnt,
  output logic [15:0]       oFlushCnt,
`endif
  input  logic              iRedirect,
  input  logic [ADDR_W-1:0] iTarget
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] issue_pc_q, issue_pc_d;
  logic              inflight_q, inflight_d;
  logic [CW-1:0]     count;
  logic              full, empty;
  logic              issue, push, pop;
  logic [DATA_W+ADDR_W-1:0] head;

  eprisc_fetch_fifo #(
    .DEPTH (DEPTH),
    .W     (DATA_W + ADDR_W)
  ) u_fifo (
    .clk   (iClk),
    .rst   (iRst),
    .push  (push),
    .pop   (pop),
    .flush (iRedirect),
    .wdata ({iRomData, issue_pc_q}),
    .rdata (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  assign oRomAddr           = pc_q;
  assign oRomEn             = inflight_q;
  assign oValid             = !empty;
  assign {oInstr, oInstrPC} = head;

  // Credit uses the pre-pop count, so an in-flight word always has room.
  assign issue = !iRedirect && !full &&
                 ((count + CW'(inflight_q)) < CW'(DEPTH));
  assign push  = inflight_q && !iRedirect;
  assign pop   = !empty && iReady && !iRedirect;

  always_comb begin
    pc_d       = pc_q;
    issue_pc_d = issue_pc_q;
    inflight_d = issue;
    if (iRedirect) begin
      pc_d = iTarget;
    end else if (issue) begin
      pc_d       = pc_q + 1'b1;
      issue_pc_d = pc_q;
    end
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      pc_q       <= RESET_PC;
      issue_pc_q <= '0;
      inflight_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      issue_pc_q <= issue_pc_d;
      inflight_q <= inflight_d;
    end
  end

`ifdef EPRISC_FETCH_PERF_EN
  logic [15:0] fetch_cnt_q, fetch_cnt_d;
  logic [15:0] flush_cnt_q, flush_cnt_d;

  assign oFetchCnt = fetch_cnt_q;
  assign oFlushCnt = flush_cnt_q;

  always_comb begin
    fetch_cnt_d = fetch_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (push && fetch_cnt_q != 16'hFFFF) begin
      fetch_cnt_d = fetch_cnt_q + 1'b1;
    end
    if (iRedirect && flush_cnt_q != 16'hFFFF) begin
      flush_cnt_d = flush_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      fetch_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end
`endif

endmodule

// File: tb/tb_eprisc_fetch_unit.sv
// Bench for eprisc_fetch_unit with a 1-cycle-latency ROM model
// and an in-order scoreboard of {instr, pc}.
module tb_eprisc_fetch_unit;
  import eprisc_pkg::*;

  logic        iClk = 1'b0;
  logic        iRst;
  logic [7:0]  oRomAddr;
  logic        oRomEn;
  logic [31:0] iRomData;
  logic        oValid;
  logic [31:0] oInstr;
  logic [7:0]  oInstrPC;
  logic        iReady;
  logic        iRedirect;
  logic [7:0]  iTarget;
`ifdef EPRISC_FETCH_PERF_EN
  logic [15:0] oFetchCnt;
  logic [15:0] oFlushCnt;
`endif

  int checks = 0;
  int passes = 0;
  fetch_entry_t exp_q[$];

  always #5 iClk = ~iClk;

  eprisc_fetch_unit dut (
    .iClk      (iClk),
    .iRst      (iRst),
    .oRomAddr  (oRomAddr),
    .oRomEn    (oRomEn),
    .iRomData  (iRomData),
    .oValid    (oValid),
    .oInstr    (oInstr),
    .oInstrPC  (oInstrPC),
    .iReady    (iReady),
`ifdef EPRISC_FETCH_PERF_EN
    .oFetchCnt (oFetchCnt),
    .oFlushCnt (oFlushCnt),
`endif
    .iRedirect (iRedirect),
    .iTarget   (iTarget)
  );

  function automatic logic [31:0] rom_word(input logic [7:0] a);
    case (a)
      8'h00:   rom_word = 32'h24413345;
      8'h01:   rom_word = 32'h25000000;
      8'h0F:   rom_word = 32'h66400004;
      default: rom_word = {8'hC0, a, 8'h5A, ~a};
    endcase
  endfunction

  always @(posedge iClk) iRomData <= rom_word(oRomAddr);

  // Scoreboard: every accepted head must match the next expected entry.
  always @(negedge iClk) begin
    if (!iRst && oValid && iReady && !iRedirect) begin
      checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL sb_extra: got pc=%h instr=%h, required no output",
                 oInstrPC, oInstr);
      end else begin
        fetch_entry_t e;
        e = exp_q.pop_front();
        if (oInstr !== e.instr || oInstrPC !== e.pc)
          $display("FAIL sb_order: got pc=%h instr=%h, required pc=%h instr=%h",
                   oInstrPC, oInstr, e.pc, e.instr);
        else passes++;
      end
    end
  end

  task automatic step();
    @(posedge iClk);
    #1;
  endtask

  task automatic restart_sb(input logic [7:0] start);
    exp_q.delete();
    for (int i = 0; i < 64; i++) begin
      fetch_entry_t e;
      e.pc    = 8'(start + 8'(i));
      e.instr = rom_word(e.pc);
      exp_q.push_back(e);
    end
  endtask

  task automatic test_reset();
    iRst = 1'b1; iReady = 1'b0; iRedirect = 1'b0; iTarget = 8'h00;
    step(); step();
    @(negedge iClk);
    checks++;
    if (oValid !== 1'b0 || oRomEn !== 1'b0 || oInstr !== 32'h0 ||
        oInstrPC !== 8'h00 || oRomAddr !== 8'h00)
      $display("FAIL reset_outs: got v=%b en=%b instr=%h pc=%h addr=%h, required all 0",
               oValid, oRomEn, oInstr, oInstrPC, oRomAddr);
    else passes++;
`ifdef EPRISC_FETCH_PERF_EN
    checks++;
    if (oFetchCnt !== 16'h0 || oFlushCnt !== 16'h0)
      $display("FAIL reset_perf: got %h/%h, required 0/0", oFetchCnt, oFlushCnt);
    else passes++;
`endif
  endtask

  task automatic test_latency();
    iReady = 1'b1;
    restart_sb(8'h00);
    step();
    iRst = 1'b0;
    @(negedge iClk);
    checks++;
    if (oRomAddr !== 8'h00 || oRomEn !== 1'b0 || oValid !== 1'b0)
      $display("FAIL lat_c: got addr=%h en=%b v=%b, required 00/0/0",
               oRomAddr, oRomEn, oValid);
    else passes++;
    step();
    @(negedge iClk);
    checks++;
    if (oRomEn !== 1'b1 || oValid !== 1'b0 || oRomAddr !== 8'h01)
      $display("FAIL lat_c1: got en=%b v=%b addr=%h, required 1/0/01",
               oRomEn, oValid, oRomAddr);
    else passes++;
    step();
    @(negedge iClk);
    checks++;
    if (oValid !== 1'b1 || oInstr !== 32'h24413345 || oInstrPC !== 8'h00)
      $display("FAIL lat_c2: got v=%b instr=%h pc=%h, required 1/24413345/00",
               oValid, oInstr, oInstrPC);
    else passes++;
    step();
    @(negedge iClk);
    checks++;
    if (oValid !== 1'b1 || oInstr !== 32'h25000000 || oInstrPC !== 8'h01)
      $display("FAIL lat_c3: got v=%b instr=%h pc=%h, required 1/25000000/01",
               oValid, oInstr, oInstrPC);
    else passes++;
    repeat (4) step();
  endtask

  task automatic test_backpressure();
    iRst = 1'b1; iReady = 1'b0;
    step();
    restart_sb(8'h00);
    iRst = 1'b0;
    repeat (10) step();
    @(negedge iClk);
    checks++;
    if (dut.u_fifo.count !== 3'd4 || oRomAddr !== 8'h04 ||
        oRomEn !== 1'b0 || oValid !== 1'b1)
      $display("FAIL bp_full: got cnt=%0d addr=%h en=%b v=%b, required 4/04/0/1",
               dut.u_fifo.count, oRomAddr, oRomEn, oValid);
    else passes++;
`ifdef EPRISC_FETCH_PERF_EN
    checks++;
    if (oFetchCnt !== 16'd4)
      $display("FAIL bp_perf: got fetch=%0d, required 4", oFetchCnt);
    else passes++;
`endif
    step();
    iReady = 1'b1;
    @(negedge iClk);
    repeat (11) begin
      step();
      @(negedge iClk);
    end
    #1;
    checks++;
    if (exp_q.size() != 52)
      $display("FAIL bp_drain: got %0d left, required 52", exp_q.size());
    else passes++;
  endtask

  task automatic test_redirect_mid();
    step();
    iRedirect = 1'b1; iTarget = 8'h0F;
    restart_sb(8'h0F);
    @(negedge iClk);
    checks++;
    if (oRomEn !== 1'b1)
      $display("FAIL rd_inflight: got en=%b, required 1", oRomEn);
    else passes++;
    step();
    iRedirect = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge iClk);
      checks++;
      if (oValid !== 1'b0)
        $display("FAIL rd_gap%0d: got v=%b, required 0", i, oValid);
      else passes++;
      step();
    end
    @(negedge iClk);
    checks++;
    if (oValid !== 1'b1 || oInstr !== 32'h66400004 || oInstrPC !== 8'h0F)
      $display("FAIL rd_first: got v=%b instr=%h pc=%h, required 1/66400004/0f",
               oValid, oInstr, oInstrPC);
    else passes++;
    repeat (3) step();
  endtask

  task automatic test_redirect_pop();
    step();
    iRedirect = 1'b1; iTarget = 8'h40;
    restart_sb(8'h40);
    @(negedge iClk);
    checks++;
    if (oValid !== 1'b1)
      $display("FAIL rp_pre: got v=%b, required 1", oValid);
    else passes++;
    step();
    iRedirect = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge iClk);
      checks++;
      if (oValid !== 1'b0)
        $display("FAIL rp_gap%0d: got v=%b, required 0", i, oValid);
      else passes++;
      step();
    end
    @(negedge iClk);
    checks++;
    if (oValid !== 1'b1 || oInstrPC !== 8'h40)
      $display("FAIL rp_first: got v=%b pc=%h, required 1/40", oValid, oInstrPC);
    else passes++;
    step();
  endtask

  task automatic test_wrap();
    logic [7:0] exp_pc;
    step();
    iRedirect = 1'b1; iTarget = 8'hFE;
    restart_sb(8'hFE);
    step();
    iRedirect = 1'b0;
    step(); step();
    exp_pc = 8'hFE;
    for (int i = 0; i < 4; i++) begin
      @(negedge iClk);
      checks++;
      if (oValid !== 1'b1 || oInstrPC !== exp_pc)
        $display("FAIL wrap%0d: got v=%b pc=%h, required 1/%h",
                 i, oValid, oInstrPC, exp_pc);
      else passes++;
      exp_pc = exp_pc + 8'h01;
      step();
    end
`ifdef EPRISC_FETCH_PERF_EN
    checks++;
    if (oFlushCnt !== 16'd3)
      $display("FAIL wrap_perf: got flush=%0d, required 3", oFlushCnt);
    else passes++;
`endif
  endtask

  task automatic test_reset_mid();
    iRst = 1'b1; iReady = 1'b0;
    step();
    exp_q.delete();
    iRst = 1'b0;
    repeat (4) step();
    @(negedge iClk);
    checks++;
    if (oRomEn !== 1'b1 || oValid !== 1'b1 || oRomAddr !== 8'h04)
      $display("FAIL rm_pre: got en=%b v=%b addr=%h, required 1/1/04",
               oRomEn, oValid, oRomAddr);
    else passes++;
    iRst = 1'b1;
    step();
    restart_sb(8'h00);
    iRst = 1'b0; iReady = 1'b1;
    @(negedge iClk);
    checks++;
    if (oValid !== 1'b0 || oRomAddr !== 8'h00 || oRomEn !== 1'b0)
      $display("FAIL rm_after: got v=%b addr=%h en=%b, required 0/00/0",
               oValid, oRomAddr, oRomEn);
    else passes++;
`ifdef EPRISC_FETCH_PERF_EN
    checks++;
    if (oFetchCnt !== 16'h0 || oFlushCnt !== 16'h0)
      $display("FAIL rm_perf: got %h/%h, required 0/0", oFetchCnt, oFlushCnt);
    else passes++;
`endif
    step(); step();
    @(negedge iClk);
    checks++;
    if (oValid !== 1'b1 || oInstr !== 32'h24413345 || oInstrPC !== 8'h00)
      $display("FAIL rm_refetch: got v=%b instr=%h pc=%h, required 1/24413345/00",
               oValid, oInstr, oInstrPC);
    else passes++;
    repeat (3) step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    iRst = 1'b1; iReady = 1'b0; iRedirect = 1'b0; iTarget = 8'h00;
    test_reset();
    test_latency();
    test_backpressure();
    test_redirect_mid();
    test_redirect_pop();
    test_wrap();
    test_reset_mid();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
